// File: rtl/tp_host_loader.sv
// tp_host_loader: host-side command FIFO, SPI frame shifter and run launcher
// for the tiny processor's uio mode-select / serial pins.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   cmd_valid_in/ready  command push handshake (ready = FIFO not full)
//   cmd_type/addr/data  00 iwrite, 01 dwrite, 10 run, 11 reserved (dropped)
//   ctrl_out            mode select: 01 icache wr, 10 dcache wr, 11 run
//   miso_out, sclk_in   serial frame {addr,data} MSB first, processor clock
//   proc_done_in        processor idle flag
//   busy_out            FSM active or FIFO non-empty
//   run_done_out        one-cycle pulse at run completion
//   run_cycles_out      cycles spent in RUN, saturating
//   timeout_out         sticky run-timeout flag
// Optional feature: define TP_LOADER_TIMEOUT_EN to abort runs after
// TIMEOUT_CYC cycles; otherwise RUN waits indefinitely.

module tp_host_loader #(
  parameter int FIFO_DEPTH  = 4,
  parameter int FRAME_BITS  = 12,
  parameter int GAP_CYCLES  = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_in,
  output logic        cmd_ready_out,
  input  logic [1:0]  cmd_type_in,
  input  logic [3:0]  cmd_addr_in,
  input  logic [7:0]  cmd_data_in,
  output logic [1:0]  ctrl_out,
  output logic        miso_out,
  input  logic        sclk_in,
  input  logic        proc_done_in,
  output logic        busy_out,
  output logic        run_done_out,
  output logic [15:0] run_cycles_out,
  output logic        timeout_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_SHIFT,
    S_GAP,
    S_RUN
  } state_t;

  typedef struct packed {
    logic [1:0] typ;
    logic [3:0] addr;
    logic [7:0] data;
  } cmd_t;

  state_t r_state;
  state_t w_state_nxt;

  cmd_t r_mem [FIFO_DEPTH];
  cmd_t w_head;
  cmd_t w_cmd_in;

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;

  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_rise;
  logic w_fall;
  logic w_run_end;
  logic w_run_to;

  logic                  r_sclk_q;
  logic                  r_dwr;
  logic                  r_seen_busy;
  logic                  r_run_done;
  logic [FRAME_BITS-1:0] r_shift;
  logic [BW-1:0]         r_bit_cnt;
  logic [GW-1:0]         r_gap_cnt;
  logic [15:0]           r_cyc;
  logic [15:0]           r_run_cycles;

  assign w_cmd_in = '{typ: cmd_type_in,
                      addr: cmd_addr_in,
                      data: cmd_data_in};
  assign w_head   = r_mem[r_rptr];
  assign w_empty  = (r_level == '0);

  // Ready depends only on the registered level, so a
  // same-cycle pop never frees a slot for a push.
  assign cmd_ready_out = (r_level < LW'(FIFO_DEPTH));
  assign w_push        = cmd_valid_in & cmd_ready_out;

  assign w_rise = sclk_in & ~r_sclk_q;
  assign w_fall = ~sclk_in & r_sclk_q;

  assign busy_out       = (r_state != S_IDLE) | ~w_empty;
  assign run_done_out   = r_run_done;
  assign run_cycles_out = r_run_cycles;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_cmd_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)
        r_level <= r_level + LW'(1);
      else if (!w_push && w_pop)
        r_level <= r_level - LW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_run_end   = 1'b0;
    w_run_to    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          unique case (1'b1)
            (w_head.typ == 2'b00),
            (w_head.typ == 2'b01): w_state_nxt = S_SEL;
            (w_head.typ == 2'b10): w_state_nxt = S_RUN;
            default:               w_state_nxt = S_IDLE;
          endcase
        end
      end
      S_SEL: w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (w_rise && r_bit_cnt == BW'(FRAME_BITS - 1))
          w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (r_gap_cnt == GW'(GAP_CYCLES - 1))
          w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (r_seen_busy && proc_done_in) begin
          w_run_end   = 1'b1;
          w_state_nxt = S_IDLE;
        end
`ifdef TP_LOADER_TIMEOUT_EN
        else if (r_cyc == 16'(TIMEOUT_CYC - 1)) begin
          w_run_to    = 1'b1;
          w_state_nxt = S_IDLE;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl_out = 2'b00;
    miso_out = 1'b0;
    unique case (1'b1)
      (r_state == S_SEL),
      (r_state == S_SHIFT): begin
        ctrl_out = r_dwr ? 2'b10 : 2'b01;
        miso_out = r_shift[FRAME_BITS-1];
      end
      (r_state == S_RUN): ctrl_out = 2'b11;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sclk_q     <= 1'b0;
      r_dwr        <= 1'b0;
      r_seen_busy  <= 1'b0;
      r_run_done   <= 1'b0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_cyc        <= '0;
      r_run_cycles <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sclk_q   <= sclk_in;
      r_run_done <= 1'b0;
      if (w_pop) begin
        r_dwr       <= (w_head.typ == 2'b01);
        r_shift     <= FRAME_BITS'({w_head.addr, w_head.data});
        r_bit_cnt   <= '0;
        r_cyc       <= '0;
        r_seen_busy <= 1'b0;
      end
      if (r_state == S_SHIFT) begin
        if (w_rise) r_bit_cnt <= r_bit_cnt + BW'(1);
        if (w_fall) r_shift <= r_shift << 1;
      end
      if (r_state == S_GAP)
        r_gap_cnt <= r_gap_cnt + GW'(1);
      else
        r_gap_cnt <= '0;
      if (r_state == S_RUN) begin
        if (r_cyc != 16'hFFFF) r_cyc <= r_cyc + 16'd1;
        if (!proc_done_in) r_seen_busy <= 1'b1;
        if (w_run_end) begin
          r_run_done   <= 1'b1;
          r_run_cycles <= r_cyc;
        end
        if (w_run_to) begin
          r_run_done   <= 1'b1;
          r_run_cycles <= 16'(TIMEOUT_CYC);
        end
      end
    end
  end

`ifdef TP_LOADER_TIMEOUT_EN
  logic r_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout <= 1'b0;
    end else if (w_pop && w_head.typ == 2'b10) begin
      r_timeout <= 1'b0;
    end else if (w_run_to) begin
      r_timeout <= 1'b1;
    end
  end

  assign timeout_out = r_timeout;
`else
  logic w_unused_to;
  assign w_unused_to = ^{w_run_to, 16'(TIMEOUT_CYC)};
  assign timeout_out = 1'b0;
`endif

endmodule

// File: tb/tb_tp_host_loader.sv
// tb_tp_host_loader: randomized scoreboard bench for tp_host_loader.
// Emulates the processor (sclk, proc_done) and checks frames and runs.

module tb_tp_host_loader;

  localparam int TOC = 64;
  localparam int FB  = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_type = '0;
  logic [3:0]  cmd_addr = '0;
  logic [7:0]  cmd_data = '0;
  logic        sclk = 1'b0;
  logic        proc_done = 1'b1;
  logic        cmd_ready;
  logic [1:0]  ctrl;
  logic        miso;
  logic        busy;
  logic        run_done;
  logic [15:0] run_cycles;
  logic        timeout;

  tp_host_loader #(
    .FIFO_DEPTH (4),
    .FRAME_BITS (FB),
    .GAP_CYCLES (2),
    .TIMEOUT_CYC(TOC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid_in  (cmd_valid),
    .cmd_ready_out (cmd_ready),
    .cmd_type_in   (cmd_type),
    .cmd_addr_in   (cmd_addr),
    .cmd_data_in   (cmd_data),
    .ctrl_out      (ctrl),
    .miso_out      (miso),
    .sclk_in       (sclk),
    .proc_done_in  (proc_done),
    .busy_out      (busy),
    .run_done_out  (run_done),
    .run_cycles_out(run_cycles),
    .timeout_out   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          run;
    logic [1:0]  mode;
    logic [11:0] frame;
    int          cyc;
    bit          to;
  } exp_t;

  typedef struct {
    int lo;
    int hi;
  } rp_t;

  exp_t sb[$];
  rp_t  rq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   rise_cnt = 0;
  bit   in_frame = 1'b0;
  int   last_gap = -1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm, input string got,
                      input string want);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %s, expected %s", nm, got, want);
  endtask

  function automatic exp_t mk_wr(input logic [1:0] t, input logic [3:0] a,
                                 input logic [7:0] d);
    exp_t e;
    e.run   = 1'b0;
    e.mode  = (t == 2'b00) ? 2'b01 : 2'b10;
    e.frame = {a, d};
    e.cyc   = 0;
    e.to    = 1'b0;
    return e;
  endfunction

  function automatic exp_t mk_run(input int hi);
    exp_t e;
    e.run   = 1'b1;
    e.mode  = 2'b11;
    e.frame = '0;
    e.cyc   = hi;
    e.to    = 1'b0;
`ifdef TP_LOADER_TIMEOUT_EN
    if (hi >= TOC) begin
      e.cyc = TOC;
      e.to  = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic push(input logic [1:0] t, input logic [3:0] a,
                      input logic [7:0] d, input int lo = 0,
                      input int hi = 0);
    int  n;
    rp_t r;
    n = 0;
    @(negedge clk);
    cmd_type  = t;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      fail("push_ready_timeout", "ready=0", "ready=1");
      cmd_valid = 1'b0;
      return;
    end
    if (t == 2'b10) begin
      r.lo = lo;
      r.hi = hi;
      sb.push_back(mk_run(hi));
      rq.push_back(r);
    end else if (t != 2'b11) begin
      sb.push_back(mk_wr(t, a, d));
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      fail("drain_timeout", "still busy", "idle");
      sb.delete();
      rq.delete();
    end
  endtask

  // Processor emulation plus output monitor / scoreboard checker.
  initial begin : mon
    int          ph;
    int          k;
    int          idle_cnt;
    bit          in_run;
    bit          prev_write;
    bit          chk_hold;
    bit          prev_done;
    logic        held;
    logic [1:0]  fmode;
    logic [11:0] fbits;
    rp_t         rp;
    exp_t        e;
    ph = 0; k = 0; idle_cnt = 0;
    in_run = 0; prev_write = 0;
    chk_hold = 0; prev_done = 0;
    held = 0; fmode = 0; fbits = 0;
    rp.lo = 1; rp.hi = 3;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 0; in_run = 0; rise_cnt = 0;
        sclk = 0; proc_done = 1; prev_write = 0;
        chk_hold = 0; prev_done = 0; idle_cnt = 0;
      end else begin
        if (prev_done)
          check("run_done_one_cycle", 32'(run_done), 0);
        prev_done = run_done;
        if (run_done) begin
          if (sb.size() == 0 || !sb[0].run) begin
            fail("run_done_unexpected", "pulse", "no pulse");
          end else begin
            e = sb.pop_front();
            check("run_cycles", 32'(run_cycles), e.cyc);
            check("timeout_flag", 32'(timeout), 32'(e.to));
          end
        end
        if (in_frame) begin
          if (rise_cnt == FB) begin
            check("frame_end_ctrl", 32'(ctrl), 0);
            sclk = 0; in_frame = 0;
            prev_write = 1; idle_cnt = 1;
            if (sb.size() == 0 || sb[0].run) begin
              fail("frame_unexpected", "frame", "none");
            end else begin
              e = sb.pop_front();
              check("frame_mode", 32'(fmode), 32'(e.mode));
              check("frame_bits", 32'(fbits), 32'(e.frame));
            end
          end else begin
            if (chk_hold)
              check("miso_hold", 32'(miso), 32'(held));
            chk_hold = 0;
            ph++;
            if (ph > 8 * FB + 16) begin
              fail("frame_stall", "no end", "12 bits");
              in_frame = 0;
              sclk = 0;
            end else if ((ph % 8) >= 4 && !sclk) begin
              held  = miso;
              fbits = {fbits[10:0], miso};
              rise_cnt++;
              chk_hold = 1;
              sclk = 1;
            end else if ((ph % 8) < 4) begin
              sclk = 0;
            end
          end
        end else if (ctrl == 2'b01 || ctrl == 2'b10) begin
          in_frame = 1; ph = 0; rise_cnt = 0;
          fmode = ctrl; fbits = 0;
          sclk = 0; chk_hold = 0;
          if (prev_write) last_gap = idle_cnt;
          prev_write = 0;
          in_run = 0; proc_done = 1;
        end else if (ctrl == 2'b11) begin
          if (!in_run) begin
            in_run = 1; k = 0; prev_write = 0;
            if (rq.size() == 0) begin
              fail("run_unexpected", "ctrl=11", "no run");
              rp.lo = 1; rp.hi = 3;
            end else begin
              rp = rq.pop_front();
            end
          end else begin
            k++;
          end
          proc_done = (k >= rp.lo && k < rp.hi) ? 1'b0 : 1'b1;
        end else begin
          idle_cnt++;
          if (in_run) begin
            in_run = 0;
            proc_done = 1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #(3_000_000);
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin : stim
    int n;
    int r;
    int lo;
    int hi;
    logic [1:0] t;

    #3 rst_n = 1'b0;
    #1;
    check("rst_ctrl", 32'(ctrl), 0);
    check("rst_miso", 32'(miso), 0);
    check("rst_run_done", 32'(run_done), 0);
    check("rst_run_cycles", 32'(run_cycles), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_ready", 32'(cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    push(2'b00, 4'h3, 8'hA5);
    drain();

    last_gap = -1;
    push(2'b00, 4'h1, 8'h5A);
    push(2'b01, 4'h2, 8'hC3);
    drain();
    check("gap_cycles", 32'(last_gap), 3);

    push(2'b01, 4'h9, 8'h3C);
    push(2'b10, 4'h0, 8'h00, 2, 22);
    drain();
    check("run_cycles_hold", 32'(run_cycles), 22);

    push(2'b10, 4'h0, 8'h00, 2, 50);
    n = 0;
    while (ctrl != 2'b11 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail("run_start", "no ctrl=11", "ctrl=11");
    check("busy_in_run", 32'(busy), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ready_fill", 32'(cmd_ready), (i < 4) ? 1 : 0);
      cmd_type  = 2'(i % 2);
      cmd_addr  = 4'(i + 4);
      cmd_data  = 8'($urandom);
      cmd_valid = 1'b1;
      if (cmd_ready)
        sb.push_back(mk_wr(cmd_type, cmd_addr, cmd_data));
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end
    @(negedge clk);
    check("ready_full_hold", 32'(cmd_ready), 0);
    check("ctrl_still_run", 32'(ctrl), 3);
    drain();

    push(2'b11, 4'h7, 8'h11);
    repeat (4) begin
      @(negedge clk);
      check("reserved_ctrl_idle", 32'(ctrl), 0);
    end
    check("reserved_dropped", 32'(busy), 0);
    push(2'b11, 4'h2, 8'h22);
    push(2'b00, 4'h4, 8'h96);
    drain();

    for (int i = 0; i < 30; i++) begin
      r  = int'($urandom_range(0, 9));
      t  = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 :
           (r == 8) ? 2'b10 : 2'b11;
      lo = int'($urandom_range(1, 4));
      hi = lo + int'($urandom_range(2, 30));
      push(t, 4'($urandom), 8'($urandom), lo, hi);
      repeat (int'($urandom_range(0, 15))) @(negedge clk);
    end
    drain();

    push(2'b00, 4'hF, 8'hFF);
    push(2'b01, 4'h1, 8'h01);
    push(2'b10, 4'h0, 8'h00, 2, 10);
    n = 0;
    while (!(in_frame && rise_cnt == 6) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail("reach_bit6", "not reached", "bit 6");
    check("ctrl_pre_reset", 32'(ctrl), 1);
    check("miso_pre_reset", 32'(miso), 1);
    #2 rst_n = 1'b0;
    sb.delete();
    rq.delete();
    #1;
    check("arst_ctrl", 32'(ctrl), 0);
    check("arst_miso", 32'(miso), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_ready", 32'(cmd_ready), 1);
    check("arst_run_cycles", 32'(run_cycles), 0);
    check("arst_run_done", 32'(run_done), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(cmd_ready), 1);
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_ctrl", 32'(ctrl), 0);
    push(2'b01, 4'h6, 8'h42);
    drain();

`ifdef TP_LOADER_TIMEOUT_EN
    push(2'b10, 4'h0, 8'h00, 2, 1000000);
    drain();
    repeat (3) @(negedge clk);
    check("timeout_sticky", 32'(timeout), 1);
    check("timeout_ctrl", 32'(ctrl), 0);
    push(2'b10, 4'h0, 8'h00, 1, 5);
    drain();
    check("timeout_cleared", 32'(timeout), 0);
`endif

    check("final_idle", 32'(busy), 0);
    check("final_sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
